// File: rtl/calc_serial_varcalc_pkg.sv
// Shared constants for the serial window variance calculator:
// default widths, the legal sample-count limit and the FSM state encoding.
package calc_serial_pkg;

    localparam int unsigned SUM_W = 11;
    localparam int unsigned SQ_W  = 14;
    localparam int unsigned N_W   = 9;
    localparam int unsigned RES_W = 22;
    localparam int unsigned N_MAX = 256;

    // Legacy-compatible 3-bit state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_MUL_A = 3'd1;
    localparam logic [2:0] ST_MUL_B = 3'd2;
    localparam logic [2:0] ST_SUB   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/calc_serial_varcalc_if.sv
// Start/ack handshake bundle between the window calculator, the variance
// calculator (slave) and the downstream comparison stage (master side).
interface calc_serial_varcalc_if
    import calc_serial_pkg::*;
#(
    parameter int unsigned SUM_W = calc_serial_pkg::SUM_W,
    parameter int unsigned SQ_W  = calc_serial_pkg::SQ_W,
    parameter int unsigned N_W   = calc_serial_pkg::N_W,
    parameter int unsigned RES_W = calc_serial_pkg::RES_W
) ();

    logic             start;
    logic [N_W-1:0]   n;
    logic [SUM_W-1:0] wsum;
    logic [SQ_W-1:0]  w2sum;
    logic             ack;
    logic             busy;
    logic             valid;
    logic [RES_W-1:0] result;
    logic             err;

    modport slave (
        input  start, n, wsum, w2sum, ack,
        output busy, valid, result, err
    );

    modport master (
        output start, n, wsum, w2sum, ack,
        input  busy, valid, result, err
    );

endinterface

// File: rtl/calc_serial_varcalc_shiftmul.sv
// One shift-add multiply step: adds the multiplicand, shifted by the
// current bit position, into the accumulator when the multiplier bit is set.
module calc_serial_shiftmul #(
    parameter int unsigned ACC_W = 23,
    parameter int unsigned CNT_W = 4
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [ACC_W-1:0] mcand_i,
    input  logic             mbit_i,
    input  logic [CNT_W-1:0] shift_i,
    output logic [ACC_W-1:0] acc_o
);

    logic [ACC_W-1:0] partial;

    always_comb begin
        partial = mcand_i << shift_i;
        acc_o   = mbit_i ? (acc_i + partial) : acc_i;
    end

endmodule

// File: rtl/calc_serial_varcalc.sv
// Serial variance numerator n*w2sum - wsum^2 computed with one time-shared
// shift-add multiplier; fixed 21-cycle start-to-valid latency.
module calc_serial_varcalc
    import calc_serial_pkg::*;
#(
    parameter int unsigned SUM_W = calc_serial_pkg::SUM_W,
    parameter int unsigned SQ_W  = calc_serial_pkg::SQ_W,
    parameter int unsigned N_W   = calc_serial_pkg::N_W,
    parameter int unsigned RES_W = calc_serial_pkg::RES_W
) (
    input  logic                  clk,
    input  logic                  reset,
    calc_serial_varcalc_if.slave  bus
);

    localparam int unsigned PA_W      = SQ_W + N_W;
    localparam int unsigned PB_W      = 2 * SUM_W;
    localparam int unsigned ACC_W     = max_u(PA_W, PB_W);
    localparam int unsigned MUL_STEPS = max_u(N_W, SUM_W);
    localparam int unsigned CNT_W     = $clog2(MUL_STEPS);

    logic [2:0]       state_q,  state_d;
    logic [N_W-1:0]   op_n_q,   op_n_d;
    logic [SUM_W-1:0] op_sum_q, op_sum_d;
    logic [SQ_W-1:0]  op_sq_q,  op_sq_d;
    logic [ACC_W-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [ACC_W-1:0] pa_q,     pa_d;
    logic [ACC_W-1:0] pb_q,     pb_d;
    logic             busy_q,   busy_d;
    logic             valid_q,  valid_d;
    logic [RES_W-1:0] result_q, result_d;
    logic             err_q,    err_d;

    logic [ACC_W-1:0] mcand;
    logic [ACC_W-1:0] mplier;
    logic             mbit;
    logic [ACC_W-1:0] acc_next;
    logic             last_a;
    logic             last_b;
    logic             n_bad;

    // Operand muxes: MUL_A forms w2sum*n, MUL_B forms wsum*wsum
    always_comb begin
        if (state_q == ST_MUL_A) begin
            mcand  = ACC_W'(op_sq_q);
            mplier = ACC_W'(op_n_q);
        end else begin
            mcand  = ACC_W'(op_sum_q);
            mplier = ACC_W'(op_sum_q);
        end
        mbit   = |(mplier & (ACC_W'(1) << cnt_q));
        last_a = (cnt_q == CNT_W'(N_W - 1));
        last_b = (cnt_q == CNT_W'(SUM_W - 1));
        n_bad  = (op_n_q == '0) || (32'(op_n_q) > N_MAX);
    end

    calc_serial_shiftmul #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_shiftmul (
        .acc_i   (acc_q),
        .mcand_i (mcand),
        .mbit_i  (mbit),
        .shift_i (cnt_q),
        .acc_o   (acc_next)
    );

    always_comb begin
        state_d  = state_q;
        op_n_d   = op_n_q;
        op_sum_d = op_sum_q;
        op_sq_d  = op_sq_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        pa_d     = pa_q;
        pb_d     = pb_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_n_d   = bus.n;
                    op_sum_d = bus.wsum;
                    op_sq_d  = bus.w2sum;
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_MUL_A;
                end
            end

            ST_MUL_A: begin
                acc_d = acc_next;
                cnt_d = cnt_q + 1'b1;
                if (last_a) begin
                    pa_d    = acc_next;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_MUL_B;
                end
            end

            ST_MUL_B: begin
                acc_d = acc_next;
                cnt_d = cnt_q + 1'b1;
                if (last_b) begin
                    pb_d    = acc_next;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SUB;
                end
            end

            // Full-width compare before narrowing to RES_W
            ST_SUB: begin
                if (n_bad || (pa_q < pb_q)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                end else begin
                    result_d = RES_W'(pa_q - pb_q);
                    err_d    = 1'b0;
                end
                valid_d = 1'b1;
                state_d = ST_DONE;
            end

            ST_DONE: begin
                if (bus.ack) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_n_q   <= '0;
            op_sum_q <= '0;
            op_sq_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            pa_q     <= '0;
            pb_q     <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_n_q   <= op_n_d;
            op_sum_q <= op_sum_d;
            op_sq_q  <= op_sq_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            pa_q     <= pa_d;
            pb_q     <= pb_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.valid  = valid_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_calc_serial_varcalc.sv
// Self-checking bench for calc_serial_varcalc: directed corner cases plus
// randomized windows checked against an arithmetic reference model.
module tb_calc_serial_varcalc;

    localparam int unsigned SUM_W = 11;
    localparam int unsigned SQ_W  = 14;
    localparam int unsigned N_W   = 9;
    localparam int unsigned RES_W = 22;
    localparam int unsigned LATENCY = 21;

    logic clk = 1'b0;
    logic reset;

    calc_serial_varcalc_if #(
        .SUM_W (SUM_W),
        .SQ_W  (SQ_W),
        .N_W   (N_W),
        .RES_W (RES_W)
    ) bus ();

    calc_serial_varcalc #(
        .SUM_W (SUM_W),
        .SQ_W  (SQ_W),
        .N_W   (N_W),
        .RES_W (RES_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: variance numerator from plain unsigned arithmetic
    task automatic model(input int unsigned n, input int unsigned s, input int unsigned s2,
                         output longint unsigned res, output bit err);
        longint unsigned pa;
        longint unsigned pb;
        pa = longint'(n) * longint'(s2);
        pb = longint'(s) * longint'(s);
        if (n == 0 || n > 256 || pa < pb) begin
            res = 0;
            err = 1'b1;
        end else begin
            res = (pa - pb) & ((64'd1 << RES_W) - 1);
            err = 1'b0;
        end
    endtask

    task automatic gen_window(output int unsigned n, output int unsigned s, output int unsigned s2);
        int unsigned v;
        if ($urandom_range(0, 3) == 0) begin
            n  = $urandom_range(0, 511);
            s  = $urandom_range(0, 2047);
            s2 = $urandom_range(0, 16383);
        end else begin
            n  = $urandom_range(1, 256);
            s  = 0;
            s2 = 0;
            for (int i = 0; i < int'(n); i++) begin
                v  = $urandom_range(0, 7);
                s  += v;
                s2 += v * v;
            end
        end
    endtask

    // One transaction; ack either held high throughout or raised after ack_wait cycles
    task automatic run_txn(input string tag, input int unsigned n, input int unsigned s,
                           input int unsigned s2, input bit ack_early, input int ack_wait);
        longint unsigned exp_res;
        bit exp_err;
        int lat;
        int stray;
        model(n, s, s2, exp_res, exp_err);

        @(negedge clk);
        bus.n     = N_W'(n);
        bus.wsum  = SUM_W'(s);
        bus.w2sum = SQ_W'(s2);
        bus.start = 1'b1;
        bus.ack   = ack_early;
        @(posedge clk);
        #1;
        check({tag, " busy_after_start"}, 64'(bus.busy), 64'd1);
        @(negedge clk);
        bus.start = 1'b0;

        lat = 0;
        while (bus.valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(LATENCY));
        check({tag, " result"}, 64'(bus.result), exp_res);
        check({tag, " err"}, 64'(bus.err), 64'(exp_err));

        if (!ack_early) begin
            for (int i = 0; i < ack_wait; i++) begin
                @(negedge clk);
                bus.start = (i % 2 == 0);
                bus.n     = N_W'($urandom_range(1, 256));
                bus.wsum  = SUM_W'($urandom_range(0, 2047));
                bus.w2sum = SQ_W'($urandom_range(0, 16383));
                @(posedge clk);
                #1;
                check({tag, " hold_valid"}, 64'(bus.valid), 64'd1);
                check({tag, " hold_result"}, 64'(bus.result), exp_res);
            end
            @(negedge clk);
            bus.start = 1'b1;
            bus.ack   = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, " valid_after_ack"}, 64'(bus.valid), 64'd0);
        check({tag, " busy_after_ack"}, 64'(bus.busy), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.ack   = 1'b0;

        if (!ack_early) begin
            stray = 0;
            for (int i = 0; i < 25; i++) begin
                @(posedge clk);
                #1;
                if (bus.valid === 1'b1 || bus.busy === 1'b1) stray++;
            end
            check({tag, " no_stray_result"}, 64'(stray), 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1);
    end

    initial begin
        int unsigned rn, rs, rs2;

        bus.start = 1'b0;
        bus.ack   = 1'b0;
        bus.n     = '0;
        bus.wsum  = '0;
        bus.w2sum = '0;
        reset     = 1'b1;
        #1;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset valid", 64'(bus.valid), 64'd0);
        check("reset result", 64'(bus.result), 64'd0);
        check("reset err", 64'(bus.err), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_txn("seq1234", 4, 10, 30, 1'b1, 0);
        run_txn("all7", 256, 1792, 12544, 1'b1, 0);
        run_txn("half7", 256, 896, 6272, 1'b1, 0);
        run_txn("inconsistent", 1, 5, 0, 1'b1, 0);
        run_txn("n_zero", 0, 3, 9, 1'b1, 0);
        run_txn("n_300", 300, 10, 500, 1'b1, 0);
        run_txn("ack_late", 4, 10, 30, 1'b0, 10);

        // Asynchronous reset 12 edges into a computation, with a result still held
        run_txn("pre_reset", 3, 6, 14, 1'b1, 0);
        @(negedge clk);
        bus.n     = N_W'(5);
        bus.wsum  = SUM_W'(9);
        bus.w2sum = SQ_W'(25);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset busy", 64'(bus.busy), 64'd0);
        check("async_reset valid", 64'(bus.valid), 64'd0);
        check("async_reset result", 64'(bus.result), 64'd0);
        check("async_reset err", 64'(bus.err), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_txn("post_reset", 5, 9, 25, 1'b1, 0);

        for (int k = 0; k < 20; k++) begin
            gen_window(rn, rs, rs2);
            run_txn($sformatf("rand%0d", k), rn, rs, rs2, ($urandom_range(0, 1) == 1),
                    int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
